// File: rtl/wb_grf_pkg.sv
// rtl/wb_grf_pkg.sv - shared CPU encodings for write-data source and load extension
package wb_grf_pkg;
  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_LD  = 3'd1;
  localparam logic [2:0] WB_PC8 = 3'd2;
  localparam logic [2:0] WB_HI  = 3'd3;
  localparam logic [2:0] WB_LO  = 3'd4;
  localparam logic [2:0] WB_CP0 = 3'd5;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
endpackage

// File: rtl/wb_grf_load_ext.sv
// rtl/wb_grf_load_ext.sv - combinational load alignment and sign/zero extension
module load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] RD_W,
  input  logic [1:0]  byte_addr_W,
  input  logic [2:0]  ld_type,
  output logic [31:0] ext
);
  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half = byte_addr_W[1] ? RD_W[31:16] : RD_W[15:0];
    case (byte_addr_W)
      2'd0:    byte_v = RD_W[7:0];
      2'd1:    byte_v = RD_W[15:8];
      2'd2:    byte_v = RD_W[23:16];
      default: byte_v = RD_W[31:24];
    endcase
  end

  // Unused codes 5-7 fall through to LW.
  always_comb begin
    case (ld_type)
      LD_LH:   ext = {{16{half[15]}}, half};
      LD_LHU:  ext = {16'h0, half};
      LD_LB:   ext = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  ext = {24'h0, byte_v};
      default: ext = RD_W;
    endcase
  end
endmodule

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - writeback data select, register file with write-through, retire counter
module wb_grf
  import wb_grf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Ins_W,
  input  logic [31:0] PC_W,
  input  logic [31:0] PC8_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] RD_W,
  input  logic [1:0]  byte_addr_W,
  input  logic [31:0] HI_W,
  input  logic [31:0] LO_W,
  input  logic [31:0] CP0_RD_W,
  input  logic [2:0]  wb_sel,
  input  logic [2:0]  ld_type,
  input  logic        we,
  input  logic [4:0]  A3,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic [31:0] retired
);
  logic [31:0] regs [1:31];
  logic [31:0] retired_q;
  logic [31:0] ld_data;
  logic        wr_en;
  logic        unused_ok;

  // PC_W travels with the instruction for debug only.
  assign unused_ok = ^PC_W;

  load_ext u_load_ext (
    .RD_W        (RD_W),
    .byte_addr_W (byte_addr_W),
    .ld_type     (ld_type),
    .ext         (ld_data)
  );

  always_comb begin
    case (wb_sel)
      WB_ALU:  WD_W = AO_W;
      WB_LD:   WD_W = ld_data;
      WB_PC8:  WD_W = PC8_W;
      WB_HI:   WD_W = HI_W;
      WB_LO:   WD_W = LO_W;
      WB_CP0:  WD_W = CP0_RD_W;
      default: WD_W = 32'h0;
    endcase
  end

  assign wr_en = we && (A3 != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
    end else if (wr_en) begin
      regs[A3] <= WD_W;
    end
  end

  // Write-through so a reader in the same cycle sees the value being written.
  always_comb begin
    RD1 = 32'h0;
    RD2 = 32'h0;
    if (A1 != 5'd0) RD1 = (wr_en && A1 == A3) ? WD_W : regs[A1];
    if (A2 != 5'd0) RD2 = (wr_en && A2 == A3) ? WD_W : regs[A2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_q <= 32'h0;
    else if (Ins_W != 32'h0) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL provide these ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- Ins_W  in  32  instruction in writeback; 32'h0 = bubble
- PC_W  in  32  PC of writeback instruction
- PC8_W  in  32  PC+8 link value
- AO_W  in  32  ALU result
- RD_W  in  32  raw data-memory word
- byte_addr_W  in  2  low address bits of the load
- HI_W  in  32  HI value
- LO_W  in  32  LO value
- CP0_RD_W  in  32  CP0 read value
- wb_sel  in  3  write-data source select
- ld_type  in  3  load-extension type
- we  in  1  register write enable
- A3  in  5  destination register
- A1  in  5  read address, port 1
- A2  in  5  read address, port 2
- RD1  out  32  read data, port 1
- RD2  out  32  read data, port 2
- WD_W  out  32  final write data, used for forwarding to earlier stages
- retired  out  32  count of retired non-bubble instructions

REQ-002 Parameters: none. All encodings come from the shared package.

Function
REQ-003 wb_sel SHALL select the write data: 0 AO_W, 1 extended load, 2 PC8_W, 3 HI_W, 4 LO_W, 5 CP0_RD_W. Codes 6–7 SHALL give 32'h0.
REQ-004 ld_type SHALL select the load extension: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU. Codes 5–7 SHALL behave as LW.
REQ-005 Extension rules:
- LW: RD_W unchanged, byte_addr_W ignored.
- LH/LHU: halfword = RD_W[31:16] if byte_addr_W[1] = 1, else RD_W[15:0]. byte_addr_W[0] is ignored.
- LB/LBU: byte = RD_W[8*byte_addr_W +: 8].
- LH and LB sign-extend; LHU and LBU zero-extend.
REQ-006 WD_W SHALL be combinational from the current inputs, with zero-cycle latency.
REQ-007 The register file SHALL hold registers 1–31 of 32 bits each. Register 0 SHALL read as 0 and SHALL NOT be writable.
REQ-008 On a rising clk edge with reset high, we = 1 and A3 != 0, register A3 SHALL take WD_W.
REQ-009 Reads are combinational. When we = 1, A3 != 0 and A1 == A3, RD1 SHALL equal WD_W in the same cycle (write-through). The same rule applies to RD2 with A2.
REQ-010 A1 or A2 equal to 0 SHALL return 0 regardless of we and A3.
REQ-011 retired SHALL increment by 1 at each rising edge where Ins_W != 0. It SHALL wrap from 32'hFFFFFFFF to 0. The increment does not depend on we.
REQ-012 A write with we = 1 and A3 = 0 SHALL still count as retired if Ins_W != 0.

Reset
REQ-013 While reset = 0, all 31 registers SHALL be 0 and retired SHALL be 0, asynchronously and without waiting for a clk edge.
REQ-014 A register write or counter increment coinciding with reset = 0 SHALL be discarded.
REQ-015 During reset, RD1, RD2 and WD_W SHALL still follow REQ-003 to REQ-010, with all stored registers reading as 0.
REQ-016 The first write after reset SHALL occur at the first rising edge where reset = 1.

Structure
REQ-017 The wb_sel and ld_type encodings SHALL be constants in the shared CPU package, used by both the controller and this block.
REQ-018 Load extension SHALL be a sub-module named load_ext (RD_W, byte_addr_W, ld_type -> extended word). It SHALL be purely combinational.
REQ-019 The register array, write-through bypass and retired counter SHALL sit in wb_grf. There SHALL be no other state.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load extension: RD_W = 32'h8001_F07F.
  - LB, byte_addr 0: WD_W = 32'h0000_007F.
  - LB, byte_addr 1: WD_W = 32'hFFFF_FFF0.
  - LBU, byte_addr 1: WD_W = 32'h0000_00F0.
  - LH, byte_addr 2: WD_W = 32'hFFFF_8001.
  - LHU, byte_addr 3: WD_W = 32'h0000_8001.
- Write-through: wb_sel = 0, AO_W = 32'h1234_5678, we = 1, A3 = 5, A1 = 5.
  - Same cycle: RD1 = 32'h1234_5678.
  - After the edge with we = 0: RD1 stays 32'h1234_5678.
- Register zero: we = 1, A3 = 0, AO_W = 32'hFFFF_FFFF, A1 = 0, Ins_W = 32'h1 -> RD1 = 0 before and after the edge; retired increments by 1.
- Sources and counter:
  - wb_sel = 2, PC8_W = 32'h0000_3008: WD_W = 32'h0000_3008.
  - wb_sel = 6: WD_W = 0.
  - 3 cycles with Ins_W = 32'h0 then 2 non-zero: retired = 2.
- Wrap: force retired to 32'hFFFF_FFFF, then one non-zero Ins_W edge -> retired = 0.
- Reset mid-operation:
  - Write 32'hDEAD_BEEF to register 7, then drive reset = 0 between edges: RD(A = 7) = 0 immediately.
  - A simultaneous we = 1 edge while reset = 0 is discarded.
  - After reset returns high, the next write lands normally.
